// File: rtl/cla_pipe_if.sv
// cla_pipe_if: valid/ready handshake and data bus for cla_pipe.
// The ovf/zero/neg flag signals exist only when CLA_PIPE_FLAGS_EN is defined.
interface cla_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_PIPE_FLAGS_EN
  logic             ovf;
  logic             zero;
  logic             neg;
`endif

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, num1, num2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CLA_PIPE_FLAGS_EN
    , ovf, zero, neg
`endif
  );

  // Adder side: consumes operands and presents results.
  modport slave (
    input  in_valid, num1, num2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CLA_PIPE_FLAGS_EN
    , ovf, zero, neg
`endif
  );
endinterface

// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor.
// The operand is cut into STAGES slices of WIDTH/STAGES bits; stage k resolves
// slice k with a lookahead block and hands its carry to stage k+1. Each stage
// stalls independently so bubbles collapse under backpressure.
// WIDTH must be a multiple of STAGES.
// Optional feature: define CLA_PIPE_FLAGS_EN to build the ovf/zero/neg flags.
module cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic      clk,
  input  logic      rst,
  cla_pipe_if.slave bus
);

  localparam int S = WIDTH / STAGES;

  // Flat sum-of-products lookahead: every carry is built directly from the
  // slice generate/propagate terms and the slice carry-in.
  function automatic logic [S:0] lookahead(input logic [S-1:0] g,
                                           input logic [S-1:0] p,
                                           input logic         c0);
    logic [S:0] c;
    logic       term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < S; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be consumed from this stage upward.
    localparam int HW = WIDTH - k * S;

    logic [HW-1:0]      w_a;
    logic [HW-1:0]      w_b;
    logic               w_cin;
    logic               w_vin;
    logic               w_adv;
    logic [S-1:0]       w_g;
    logic [S-1:0]       w_p;
    logic [S:0]         w_c;
    logic [(k+1)*S-1:0] w_snew;
    logic               r_v;
    logic               r_c;
    logic [(k+1)*S-1:0] r_s;

    if (k == 0) begin : g_src
      assign w_a    = bus.num1;
      assign w_b    = bus.sub ? ~bus.num2 : bus.num2;
      assign w_cin  = bus.cin ^ bus.sub;
      assign w_vin  = bus.in_valid;
      assign w_snew = w_p ^ w_c[S-1:0];
    end else begin : g_src
      assign w_a    = g_stage[k-1].g_fwd.r_a;
      assign w_b    = g_stage[k-1].g_fwd.r_b;
      assign w_cin  = g_stage[k-1].r_c;
      assign w_vin  = g_stage[k-1].r_v;
      assign w_snew = {w_p ^ w_c[S-1:0], g_stage[k-1].r_s};
    end

    if (k == STAGES - 1) begin : g_adv
      assign w_adv = !r_v || bus.out_ready;
    end else begin : g_adv
      assign w_adv = !r_v || g_stage[k+1].w_adv;
    end

    assign w_g = w_a[S-1:0] & w_b[S-1:0];
    assign w_p = w_a[S-1:0] ^ w_b[S-1:0];
    assign w_c = lookahead(w_g, w_p, w_cin);

    // Stage register: valid bit always follows upstream when advancing,
    // data only loads on a real operation so held results stay put.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_vin;
        if (w_vin) begin
          r_c <= w_c[S];
          r_s <= w_snew;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [HW-S-1:0] r_a;
      logic [HW-S-1:0] r_b;

      // Skew register: carry the unconsumed high operand bits downstream.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vin) begin
          r_a <= w_a[HW-1:S];
          r_b <= w_b[HW-1:S];
        end
      end
    end

`ifdef CLA_PIPE_FLAGS_EN
    if (k == STAGES - 1) begin : g_flags
      logic r_ovf;
      logic r_zero;
      logic r_neg;

      // Flag register: computed from the completed sum, same timing as sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
        end else if (w_adv && w_vin) begin
          r_ovf  <= w_c[S] ^ w_c[S-1];
          r_zero <= (w_snew == '0);
          r_neg  <= w_snew[WIDTH-1];
        end
      end
    end
`endif
  end

  assign bus.in_ready  = rst || g_stage[0].w_adv;
  assign bus.out_valid = g_stage[STAGES-1].r_v;
  assign bus.sum       = g_stage[STAGES-1].r_s;
  assign bus.cout      = g_stage[STAGES-1].r_c;
`ifdef CLA_PIPE_FLAGS_EN
  assign bus.ovf       = g_stage[STAGES-1].g_flags.r_ovf;
  assign bus.zero      = g_stage[STAGES-1].g_flags.r_zero;
  assign bus.neg       = g_stage[STAGES-1].g_flags.r_neg;
`endif

endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 32-bit combinational `cla32`. The operand width is split into `STAGES` equal slices. Each slice is resolved by a carry-lookahead block in its own pipeline stage, with the carry registered between stages. It sits in the execute path behind a valid/ready handshake, giving one result per cycle at full throughput with backpressure support.

## Interface
- `WIDTH`, 32: operand and result width in bits. Must be a multiple of `STAGES`.
- `STAGES`, 4: number of pipeline stages and number of slices. Range 1..`WIDTH`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: the input operation is valid.
- `in_ready` out 1: the block accepts the input this cycle.
- `num1` in `WIDTH`: operand A.
- `num2` in `WIDTH`: operand B.
- `cin` in 1: carry-in (borrow control when subtracting).
- `sub` in 1: 0 = add, 1 = subtract.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `sum` out `WIDTH`: result.
- `cout` out 1: carry-out of the MSB.
- `ovf`, `zero`, `neg` out 1 each: flags, present only under `CLA_PIPE_FLAGS_EN`.

## Operation
- **Effective operands:** b = sub ? ~num2 : num2; c0 = cin ^ sub.
  - Result: {cout, sum} = num1 + b + c0, computed modulo 2^(WIDTH+1).
  - sub=1, cin=0 gives A−B. sub=1, cin=1 gives A−B−1.
- **Slicing:** slice width S = WIDTH/STAGES.
  - Stage k (0-based) computes bits [k·S +: S] from the operand slice plus the carry registered by stage k−1. Stage 0 uses c0.
  - Within a slice, carries come from generate/propagate lookahead, not ripple.
- **Skew:** each stage register carries:
  - the already-computed low result bits,
  - the not-yet-consumed high operand bits,
  - the inter-stage carry,
  - a valid bit v[k].
- **Flow control:** each stage advances independently, collapsing bubbles.
  - adv[STAGES−1] = !v[STAGES−1] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[0], a combinational path from out_ready.
  - A transfer occurs on in_valid && in_ready. On out_valid && out_ready the result is consumed.
- **Registers:** out_valid = v[STAGES−1]. sum and cout come from the last stage register.
- **Transparent mode (STAGES=1):** the block is a single registered stage.

## Timing
- **Reset:** v[*]=0 and all data registers cleared on the first clock edge with rst=1. After reset: out_valid=0, sum=0, cout=0, flags=0.
  - in_ready=1 while rst is high. Inputs presented during reset are discarded.
- **Reset mid-operation:** all in-flight operations are dropped and no result is emitted for them.
- **Latency:** an input accepted at edge N is presented on out_valid/sum at edge N+STAGES, with the pipe unstalled.
- **Throughput:** one result per cycle while out_ready=1.
- **Holding rules:**
  - While out_valid=1 and out_ready=0: sum, cout and flags are held stable.
  - Upstream stages keep accepting until every stage holds valid data, then in_ready=0.
  - The next result is available the cycle after the edge where out_ready=1 is sampled.
- **Simultaneous events:** when the pipe is full and out_ready=1 in the same cycle as in_valid=1, the new input is accepted and the oldest result retires on the same edge.
- **Ordering:** results always emerge in acceptance order.

## Configuration
- **`CLA_PIPE_FLAGS_EN` defined:**
  - `ovf` = signed overflow = carry into MSB ^ cout.
  - `zero` = (sum == 0).
  - `neg` = sum[WIDTH−1].
  - Flags are registered alongside sum, carry the same latency and hold rules, and reset to 0.
- **`CLA_PIPE_FLAGS_EN` undefined:** the ports are absent and no flag logic is built. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=32, STAGES=4, latency 4.
- **Carry across all slices:** num1=FFFF_FFFF, num2=0000_0001, cin=0, sub=0, out_ready=1.
  - Required 4 cycles later: sum=0000_0000, cout=1, zero=1, ovf=0.
- **Subtraction with borrow and overflow:** two operations.
  - num1=0000_0005, num2=0000_0007, sub=1, cin=0 → sum=FFFF_FFFE, cout=0, neg=1.
  - Then num1=8000_0000, num2=0000_0001, sub=1 → sum=7FFF_FFFF, ovf=1.
- **Back-to-back random stream:** 1000 random (num1, num2, cin, sub) with in_valid=1 and out_ready=1.
  - Required: one result per cycle, each matching a 33-bit reference, in order.
- **Backpressure:** stream 6 operations while holding out_ready=0.
  - Required: in_ready drops to 0 after 4 accepts, and the first result is held stable.
  - Release out_ready → all 6 results drain in order with none lost or duplicated.
- **Reset mid-flight:** accept 3 operations, then assert rst for one cycle.
  - Required: out_valid=0 and sum=0 next cycle, and no stale result ever appears.
  - A fresh operation after reset returns correctly after 4 cycles.
- **Parameter sweep:** repeat the random stream with STAGES=1 (latency 1), and with WIDTH=64, STAGES=8.
  - Required: results match the reference at the stated latency.
